// File: rtl/md_pkg.sv
// Shared op codes, latencies and helpers for the multiply/divide unit.
// MD_MADD_EN enables the multiply-accumulate op codes (100-111).
package md_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_MULT  = 3'b000;
    localparam md_op_t MD_MULTU = 3'b001;
    localparam md_op_t MD_DIV   = 3'b010;
    localparam md_op_t MD_DIVU  = 3'b011;
    localparam md_op_t MD_MADD  = 3'b100;
    localparam md_op_t MD_MADDU = 3'b101;
    localparam md_op_t MD_MSUB  = 3'b110;
    localparam md_op_t MD_MSUBU = 3'b111;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

`ifdef MD_MADD_EN
    localparam bit MD_MADD_ON = 1'b1;
`else
    localparam bit MD_MADD_ON = 1'b0;
`endif

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_op_valid(input md_op_t op);
        return !op[2] || MD_MADD_ON;
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result generator: maps op and operands to the pending {ph, pl}.
// HI/LO inputs exist only when MD_MADD_EN is defined (accumulate ops).
module md_calc
    import md_pkg::*;
(
    input  md_op_t      md_op,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
`ifdef MD_MADD_EN
    input  logic [31:0] hi,
    input  logic [31:0] lo,
`endif
    output logic [31:0] ph,
    output logic [31:0] pl,
    output logic        div0
);

    logic        [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] prod;
    logic        [63:0] res;
    logic signed [31:0] sd1;
    logic signed [31:0] sd2;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    always_comb begin
        sd1    = d1;
        sd2    = d2;
        // Low 64 bits of the sign-extended product equal the signed product.
        prod_s = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2};
        prod_u = {32'h0, d1} * {32'h0, d2};
        prod   = md_op[0] ? prod_u : prod_s;
        div0   = md_is_div(md_op) && (d2 == 32'h0);

        if (d2 == 32'h0) begin
            quo_s = '0;
            rem_s = '0;
            quo_u = '0;
            rem_u = '0;
        end else begin
            // The one signed overflow case is pinned explicitly.
            if ((d1 == 32'h8000_0000) && (d2 == 32'hFFFF_FFFF)) begin
                quo_s = 32'sh8000_0000;
                rem_s = '0;
            end else begin
                quo_s = sd1 / sd2;
                rem_s = sd1 % sd2;
            end
            quo_u = d1 / d2;
            rem_u = d1 % d2;
        end

        case (md_op)
            MD_MULT, MD_MULTU: res = prod;
            MD_DIV:            res = {rem_s, quo_s};
            MD_DIVU:           res = {rem_u, quo_u};
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU: res = {hi, lo} + prod;
            MD_MSUB, MD_MSUBU: res = {hi, lo} - prod;
`endif
            default:           res = prod;
        endcase

        ph = res[63:32];
        pl = res[31:0];
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: fixed-latency ops into private HI/LO, busy stalls ID.
// Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] ph_q, ph_d;
    logic [31:0] pl_q, pl_d;
    logic        div0_q, div0_d;
    logic [31:0] calc_ph;
    logic [31:0] calc_pl;
    logic        calc_div0;
    logic        accept;

    md_calc u_calc (
        .md_op (md_op),
        .d1    (D1),
        .d2    (D2),
`ifdef MD_MADD_EN
        .hi    (hi_q),
        .lo    (lo_q),
`endif
        .ph    (calc_ph),
        .pl    (calc_pl),
        .div0  (calc_div0)
    );

    assign accept = (state_q == MD_IDLE) && start && md_op_valid(md_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Pending result is only consumed from RUN, so it needs no reset.
    always_ff @(posedge clk) begin
        ph_q   <= ph_d;
        pl_q   <= pl_d;
        div0_q <= div0_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (accept) state_d = MD_RUN;
            MD_RUN:  if (cnt_q == 4'd0) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        ph_d   = ph_q;
        pl_d   = pl_q;
        div0_d = div0_q;
        if (accept) begin
            cnt_d  = md_is_div(md_op) ? DIV_LOAD : MULT_LOAD;
            ph_d   = calc_ph;
            pl_d   = calc_pl;
            div0_d = calc_div0;
        end else if (state_q == MD_RUN) begin
            if (cnt_q == 4'd0) begin
                if (!div0_q) begin
                    hi_d = ph_q;
                    lo_d = pl_q;
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (!start) begin
            if (mthi) hi_d = D1;
            if (mtlo) lo_d = D1;
        end
    end

    always_comb begin
        busy = (state_q == MD_RUN);
        HI   = hi_q;
        LO   = lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: timestamp-based reference model plus directed vectors.
// Honours MD_MADD_EN the same way as the design.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [2:0]  md_op;
    logic [31:0] D1, D2;
    logic        busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .D1(D1), .D2(D2), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .HI(HI), .LO(LO)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit op_ok(input logic [2:0] op);
`ifdef MD_MADD_EN
        return 1'b1;
`else
        return !op[2];
`endif
    endfunction

    // Reference arithmetic: bit 64 flags divide-by-zero, low 64 bits are {HI, LO}.
    function automatic logic [64:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
        longint          sa, sb;
        longint unsigned ua, ub, p, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        p   = op[0] ? ua * ub : longint'(sa * sb);
        acc = {h, l};
        case (op)
            3'd0, 3'd1: return {1'b0, p};
            3'd2: if (b == 0) return {1'b1, 64'h0};
                  else return {1'b0, 32'(sa % sb), 32'(sa / sb)};
            3'd3: if (b == 0) return {1'b1, 64'h0};
                  else return {1'b0, 32'(ua % ub), 32'(ua / ub)};
            3'd4, 3'd5: return {1'b0, acc + p};
            default:    return {1'b0, acc - p};
        endcase
    endfunction

    int          ecnt = 0;
    int          m_end = 0;
    bit          m_busy = 1'b0;
    bit          m_div0 = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    logic [64:0] m_calc;

    assign m_calc = ref_md(md_op, D1, D2, m_hi, m_lo);

    // Model: an accepted start at edge t lands its result at edge t+N.
    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        if (reset) begin
            m_busy <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_busy) begin
            if (ecnt == m_end) begin
                m_busy <= 1'b0;
                if (!m_div0) begin
                    m_hi <= m_res[63:32];
                    m_lo <= m_res[31:0];
                end
            end
        end else if (start && op_ok(md_op)) begin
            m_busy <= 1'b1;
            m_res  <= m_calc[63:0];
            m_div0 <= m_calc[64];
            m_end  <= ecnt + ((md_op == 3'd2 || md_op == 3'd3) ? DC : MC);
        end else if (!start) begin
            if (mthi) m_hi <= D1;
            if (mtlo) m_lo <= D1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("model_HI", HI, m_hi);
            chk("model_LO", LO, m_lo);
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        md_op = op; D1 = a; D2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] v);
        mthi = to_hi; mtlo = !to_hi; D1 = v;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        md_op = 3'd0; D1 = '0; D2 = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_HI", HI, 32'h0);
        chk("rst_LO", LO, 32'h0);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n);
        chk("mult_cycles", n, MC);
        chk("mult_HI", HI, 32'hFFFF_FFFF);
        chk("mult_LO", LO, 32'hFFFF_FFFA);

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, n);
        chk("multu_HI", HI, 32'h0000_0002);
        chk("multu_LO", LO, 32'hFFFF_FFFA);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_cycles", n, DC);
        chk("div_LO", LO, 32'hFFFF_FFFD);
        chk("div_HI", HI, 32'hFFFF_FFFF);

        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        run_op(3'd3, 32'd7, 32'd0, n);
        chk("div0_cycles", n, DC);
        chk("div0_HI", HI, 32'h11);
        chk("div0_LO", LO, 32'h22);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("divovf_LO", LO, 32'h8000_0000);
        chk("divovf_HI", HI, 32'h0);

        mt(1'b1, 32'h10);
        mt(1'b0, 32'h10);
        run_op(3'd4, 32'd2, 32'd3, n);
`ifdef MD_MADD_EN
        chk("madd_cycles", n, MC);
        chk("madd_HI", HI, 32'h10);
        chk("madd_LO", LO, 32'h16);
        run_op(3'd7, 32'd1, 32'd1, n);
        chk("msubu_HI", HI, 32'h10);
        chk("msubu_LO", LO, 32'h15);
`else
        chk("madd_cycles", n, 0);
        chk("madd_HI", HI, 32'h10);
        chk("madd_LO", LO, 32'h10);
`endif

        // Second start while busy must be dropped.
        md_op = 3'd0; D1 = 32'd7; D2 = 32'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        D1 = 32'd100; D2 = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        chk("restart_LO", LO, 32'd56);
        chk("restart_HI", HI, 32'd0);

        // mtlo while busy must be dropped.
        mt(1'b0, 32'h5);
        md_op = 3'd0; D1 = 32'd7; D2 = 32'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b1; D1 = 32'hDEAD;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_busy_LO", LO, 32'h5);
        wait_idle(n);
        chk("mtlo_busy_res", LO, 32'd56);

        // start wins over a simultaneous mtlo.
        md_op = 3'd0; D1 = 32'd2; D2 = 32'd2; start = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        chk("start_mtlo_LO", LO, 32'd56);
        wait_idle(n);
        chk("start_mtlo_res", LO, 32'd4);

        // Reset in the third busy cycle.
        md_op = 3'd0; D1 = 32'd9; D2 = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_HI", HI, 32'h0);
        chk("midrst_LO", LO, 32'h0);
        reset = 1'b0;
        run_op(3'd0, 32'd4, 32'd5, n);
        chk("post_rst_cycles", n, MC);
        chk("post_rst_LO", LO, 32'd20);
        chk("post_rst_HI", HI, 32'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
